// File: rtl/axi_vector_pkg.sv
// Chunk arithmetic shared by the vector reader and writer.
// Pure constant/combinational helpers; no state, no latency, no flow control.
// Both sides use the same rounding so their beat counts always agree.
package axi_vector_pkg;

    // Number of width-sized chunks needed to hold len bits (ceiling division).
    function automatic int chunks_for(input int len, input int width);
        return (len + width - 1) / width;
    endfunction

    // Counter width able to hold values 0..n, never narrower than one bit.
    function automatic int clog2_w(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: tvalid/tready handshake with tdata and tlast.
// No logic inside; latency and backpressure belong to the connected endpoints.
// A beat transfers on any cycle where tvalid and tready are both high.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_read_vector.sv
// Reassembles a vec_length-bit vector from AXI-Stream beats, beat i at padded bits [i*W +: W].
// ready pulses one cycle after the final handshake (one cycle after start for length 0).
// tready is high only while beats are expected; the stream may stall with tvalid low at any time.
module axi_read_vector
    import axi_vector_pkg::*;
#(
    parameter int MAX_VEC_LENGTH   = 16,
    parameter int AXI_DATA_WIDTH   = 8,
    parameter int MAX_VEC_LENGTH_W = clog2_w(MAX_VEC_LENGTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
    output logic [MAX_VEC_LENGTH-1:0]   vec,
    output logic                        last_read,
    output logic                        tlast_err,
    output logic                        ready,
    axi_stream_if.slave                 data_in
);

    localparam int MAX_CHUNKS = chunks_for(MAX_VEC_LENGTH, AXI_DATA_WIDTH);
    localparam int PADDED_W   = MAX_CHUNKS * AXI_DATA_WIDTH;
    localparam int PAD_W      = PADDED_W - MAX_VEC_LENGTH;
    localparam int CHUNK_W    = clog2_w(MAX_CHUNKS);

    typedef enum logic [1:0] {
        INIT,
        READ_CHUNK,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [MAX_VEC_LENGTH-1:0]   vec_q, vec_d;
    logic [CHUNK_W-1:0]          chunk_iter_q, chunk_iter_d;
    logic [CHUNK_W-1:0]          total_chunks_q, total_chunks_d;
    logic                        last_read_q, last_read_d;
    logic                        tlast_err_q, tlast_err_d;
    logic [PADDED_W-1:0]         beat_pad;

    // Only the top MAX_VEC_LENGTH bits of the padded buffer are ever visible, so
    // just those are kept; the beat is placed in the padded frame, then the LSB
    // padding is dropped. The buffer is cleared on start and every chunk is
    // written once, so OR-ing the beat in is a plain chunk write.
    assign beat_pad = PADDED_W'(data_in.tdata) << (int'(chunk_iter_q) * AXI_DATA_WIDTH);

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        chunk_iter_d   = chunk_iter_q;
        total_chunks_d = total_chunks_q;
        last_read_d    = last_read_q;
        tlast_err_d    = tlast_err_q;
        data_in.tready = 1'b0;
        ready          = 1'b0;

        case (state_q)
            INIT: begin
                if (start) begin
                    vec_d          = '0;
                    chunk_iter_d   = '0;
                    last_read_d    = 1'b0;
                    tlast_err_d    = 1'b0;
                    total_chunks_d = CHUNK_W'(chunks_for(int'(vec_length), AXI_DATA_WIDTH));
                    state_d        = (total_chunks_d == '0) ? DONE : READ_CHUNK;
                end
            end
            READ_CHUNK: begin
                data_in.tready = 1'b1;
                if (data_in.tvalid) begin
                    vec_d = vec_q | MAX_VEC_LENGTH'(beat_pad >> PAD_W);
                    if (chunk_iter_q == total_chunks_q - CHUNK_W'(1)) begin
                        last_read_d = data_in.tlast;
                        state_d     = DONE;
                    end else if (data_in.tlast) begin
                        tlast_err_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        chunk_iter_d = chunk_iter_q + CHUNK_W'(1);
                    end
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= INIT;
            vec_q          <= '0;
            chunk_iter_q   <= '0;
            total_chunks_q <= '0;
            last_read_q    <= 1'b0;
            tlast_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            chunk_iter_q   <= chunk_iter_d;
            total_chunks_q <= total_chunks_d;
            last_read_q    <= last_read_d;
            tlast_err_q    <= tlast_err_d;
        end
    end

    assign vec       = vec_q;
    assign last_read = last_read_q;
    assign tlast_err = tlast_err_q;

endmodule
